// File: rtl/fir_post_proc_pkg.sv
// Shared types and constants for the accelerometer FIR post-processor.
// Holds the tilt and sequencer encodings plus the filter gain reference.
package fir_post_proc_pkg;

  localparam int OUT_W_DEF = 16;
  localparam int FIR_GAIN  = 9286;

  typedef enum logic [1:0] {
    TILT_CENTER = 2'b00,
    TILT_POS    = 2'b01,
    TILT_NEG    = 2'b10
  } tilt_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SETTLE  = 2'b01,
    ST_CAPTURE = 2'b10
  } state_e;

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up arithmetic shift followed by signed saturation
// to OUT_W bits; the add is done at 33 bits so it cannot overflow.
module fir_round_sat #(
  parameter int SHIFT = 13,
  parameter int OUT_W = 16
) (
  input  logic [31:0]      din,
  output logic [OUT_W-1:0] dout
);

  localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);
  localparam logic signed [32:0] MAXV = (33'sd1 <<< (OUT_W - 1)) - 33'sd1;
  localparam logic signed [32:0] MINV = -(33'sd1 <<< (OUT_W - 1));

  logic signed [32:0] sum;
  logic signed [32:0] shifted;

  always_comb begin
    sum     = $signed({din[31], din}) + HALF;
    shifted = sum >>> SHIFT;
    if (shifted > MAXV) begin
      dout = MAXV[OUT_W-1:0];
    end else if (shifted < MINV) begin
      dout = MINV[OUT_W-1:0];
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/fir_post_proc.sv
// FIR post-processor: tick-synchronised capture, round/saturate, decimation,
// tilt hysteresis and valid/ready output. Optional min/max via FIR_POST_STATS_EN.
module fir_post_proc
  import fir_post_proc_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int SHIFT         = 13,
  parameter int OUT_W         = OUT_W_DEF,
  parameter int DECIM         = 1,
  parameter int TH_ON         = 2000,
  parameter int TH_OFF        = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_tick,
  input  logic [31:0]      fir_value,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       tilt_dir,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [OUT_W-1:0] stat_min,
  output logic [OUT_W-1:0] stat_max,
  input  logic             stat_clr
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DECIM_LAST  = 8'(DECIM - 1);
  localparam logic signed [OUT_W-1:0] TH_ON_P  = OUT_W'(TH_ON);
  localparam logic signed [OUT_W-1:0] TH_ON_N  = OUT_W'(-TH_ON);
  localparam logic signed [OUT_W-1:0] TH_OFF_P = OUT_W'(TH_OFF);
  localparam logic signed [OUT_W-1:0] TH_OFF_N = OUT_W'(-TH_OFF);

  state_e            state_reg, state_next;
  logic [3:0]        settle_cnt_reg, settle_cnt_next;
  logic              tick_prev_reg;
  logic [31:0]       fir_cap_reg;
  logic [7:0]        decim_cnt_reg;
  logic [OUT_W-1:0]  out_data_reg;
  logic              out_valid_reg;
  logic              overrun_reg;
  tilt_e             tilt_reg, tilt_next;
  logic              tick_edge, capture_en, emit;
  logic [OUT_W-1:0]  scaled;
  logic signed [OUT_W-1:0] s;

  assign tick_edge = sample_tick & ~tick_prev_reg;
  assign emit      = (state_reg == ST_CAPTURE) && (decim_cnt_reg == DECIM_LAST);
  assign s         = $signed(scaled);

  fir_round_sat #(.SHIFT(SHIFT), .OUT_W(OUT_W)) u_round_sat (
    .din  (fir_cap_reg),
    .dout (scaled)
  );

  // A fresh edge always wins: it restarts settling even mid-SETTLE or in CAPTURE.
  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    capture_en      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tick_edge) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (tick_edge) begin
          settle_cnt_next = SETTLE_LOAD;
        end else if (settle_cnt_reg == 4'd0) begin
          state_next = ST_CAPTURE;
          capture_en = 1'b1;
        end else begin
          settle_cnt_next = settle_cnt_reg - 4'd1;
        end
      end
      ST_CAPTURE: begin
        if (tick_edge) begin
          state_next      = ST_SETTLE;
          settle_cnt_next = SETTLE_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tilt_next = tilt_reg;
    case (tilt_reg)
      TILT_CENTER: begin
        if (s >= TH_ON_P)      tilt_next = TILT_POS;
        else if (s <= TH_ON_N) tilt_next = TILT_NEG;
      end
      TILT_POS: begin
        if (s <= TH_ON_N)       tilt_next = TILT_NEG;
        else if (s < TH_OFF_P)  tilt_next = TILT_CENTER;
      end
      TILT_NEG: begin
        if (s >= TH_ON_P)       tilt_next = TILT_POS;
        else if (s > TH_OFF_N)  tilt_next = TILT_CENTER;
      end
      default: tilt_next = TILT_CENTER;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= 4'd0;
      tick_prev_reg  <= 1'b0;
      fir_cap_reg    <= 32'd0;
      decim_cnt_reg  <= 8'd0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      tilt_reg       <= TILT_CENTER;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      tick_prev_reg  <= sample_tick;
      if (capture_en) fir_cap_reg <= fir_value;
      if (state_reg == ST_CAPTURE) begin
        decim_cnt_reg <= (decim_cnt_reg == DECIM_LAST) ? 8'd0 : decim_cnt_reg + 8'd1;
      end
      if (emit) begin
        out_data_reg  <= scaled;
        out_valid_reg <= 1'b1;
        tilt_reg      <= tilt_next;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
      // Overwriting an unconsumed sample beats a simultaneous clear.
      if (emit && out_valid_reg && !out_ready) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign tilt_dir  = tilt_reg;
  assign overrun   = overrun_reg;

`ifdef FIR_POST_STATS_EN
  logic signed [OUT_W-1:0] stat_min_reg, stat_max_reg;
  logic                    stat_first_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_min_reg   <= '0;
      stat_max_reg   <= '0;
      stat_first_reg <= 1'b1;
    end else if (emit) begin
      stat_first_reg <= 1'b0;
      if (stat_first_reg || stat_clr) begin
        stat_min_reg <= s;
        stat_max_reg <= s;
      end else begin
        if (s < stat_min_reg) stat_min_reg <= s;
        if (s > stat_max_reg) stat_max_reg <= s;
      end
    end else if (stat_clr) begin
      stat_min_reg   <= '0;
      stat_max_reg   <= '0;
      stat_first_reg <= 1'b1;
    end
  end

  assign stat_min = stat_min_reg;
  assign stat_max = stat_max_reg;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_min = '0;
  assign stat_max = '0;
`endif

endmodule

// File: tb/tb_fir_post_proc.sv
// Randomised self-checking bench for fir_post_proc: a DECIM=1 and a DECIM=4
// instance share stimulus and are compared against a transaction-level model.
module tb_fir_post_proc;

  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        reset_n, sample_tick, out_ready, overrun_clr, stat_clr;
  logic [31:0] fir_value;
  logic [15:0] out_data, stat_min, stat_max, out_data4, stat_min4, stat_max4;
  logic        out_valid, overrun, out_valid4, overrun4;
  logic [1:0]  tilt_dir, tilt_dir4;

  int n_vec  = 0;
  int n_miss = 0;

  // model state, index 0 = DECIM 1, index 1 = DECIM 4
  int dec_of[2] = '{1, 4};
  int m_cnt[2], m_valid[2], m_data[2], m_tilt[2], m_ovr[2];
  int m_min, m_max, m_first;

  always #5 clk = ~clk;

  fir_post_proc #(.SETTLE_CYCLES(SETTLE), .SHIFT(13), .OUT_W(16), .DECIM(1),
                  .TH_ON(2000), .TH_OFF(1000)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .fir_value(fir_value),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .tilt_dir(tilt_dir), .overrun(overrun), .overrun_clr(overrun_clr),
    .stat_min(stat_min), .stat_max(stat_max), .stat_clr(stat_clr));

  fir_post_proc #(.SETTLE_CYCLES(SETTLE), .SHIFT(13), .OUT_W(16), .DECIM(4),
                  .TH_ON(2000), .TH_OFF(1000)) dut4 (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick), .fir_value(fir_value),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
    .tilt_dir(tilt_dir4), .overrun(overrun4), .overrun_clr(overrun_clr),
    .stat_min(stat_min4), .stat_max(stat_max4), .stat_clr(stat_clr));

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // floor((v + 2^12) / 2^13) clamped to int16
  function automatic int ref_scale(input int v);
    real q;
    q = $floor((real'(v) + 4096.0) / 8192.0);
    if (q > 32767.0) return 32767;
    if (q < -32768.0) return -32768;
    return $rtoi(q);
  endfunction

  function automatic int ref_tilt(input int cur, input int s);
    if (s >= 2000 && cur != 1) return 1;
    if (s <= -2000 && cur != 2) return 2;
    if (cur == 1 && s < 1000) return 0;
    if (cur == 2 && s > -1000) return 0;
    return cur;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_valid[i] = 0; m_data[i] = 0; m_tilt[i] = 0; m_ovr[i] = 0;
    end
    m_min = 0; m_max = 0; m_first = 1;
  endtask

  task automatic model_consume(input bit rdy);
    for (int i = 0; i < 2; i++)
      if (rdy) m_valid[i] = 0;
  endtask

  task automatic model_capture(input int v, input bit rdy);
    int s;
    s = ref_scale(v);
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]++;
      if (m_cnt[i] == dec_of[i]) begin
        m_cnt[i] = 0;
        if (m_valid[i] != 0 && !rdy) m_ovr[i] = 1;
        m_data[i]  = s;
        m_valid[i] = 1;
        m_tilt[i]  = ref_tilt(m_tilt[i], s);
        if (i == 0) begin
          if (m_first != 0) begin m_min = s; m_max = s; m_first = 0; end
          else begin
            if (s < m_min) m_min = s;
            if (s > m_max) m_max = s;
          end
        end
      end else if (rdy) begin
        m_valid[i] = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, out_valid, m_valid[0]);
    check({tag, ".data"}, $signed(out_data), m_data[0]);
    check({tag, ".tilt"}, tilt_dir, m_tilt[0]);
    check({tag, ".ovr"}, overrun, m_ovr[0]);
    check({tag, ".valid4"}, out_valid4, m_valid[1]);
    check({tag, ".data4"}, $signed(out_data4), m_data[1]);
    check({tag, ".tilt4"}, tilt_dir4, m_tilt[1]);
    check({tag, ".ovr4"}, overrun4, m_ovr[1]);
`ifdef FIR_POST_STATS_EN
    check({tag, ".smin"}, $signed(stat_min), m_min);
    check({tag, ".smax"}, $signed(stat_max), m_max);
`else
    check({tag, ".smin"}, stat_min, 0);
    check({tag, ".smax"}, stat_max, 0);
`endif
  endtask

  // One tick; ready held at rdy_early until the emit edge, then rdy_emit.
  task automatic run_sample(input string tag, input int v, input bit rdy_early,
                            input bit rdy_emit);
    fir_value = v; out_ready = rdy_early; sample_tick = 1'b1;
    @(negedge clk);
    model_consume(rdy_early);
    sample_tick = 1'b0;
    repeat (SETTLE) @(negedge clk);
    check({tag, ".pre"}, out_valid, m_valid[0]);
    out_ready = rdy_emit;
    @(negedge clk);
    model_capture(v, rdy_emit);
    check_all(tag);
  endtask

  task automatic pulse_clr(input bit oc, input bit sc);
    out_ready = 1'b0; overrun_clr = oc; stat_clr = sc;
    @(negedge clk);
    if (oc) begin m_ovr[0] = 0; m_ovr[1] = 0; end
    if (sc) begin m_min = 0; m_max = 0; m_first = 1; end
    overrun_clr = 1'b0; stat_clr = 1'b0;
    check_all("clr");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check("rst.valid", out_valid, 0);
    check("rst.data", out_data, 0);
    check("rst.tilt", tilt_dir, 0);
    check("rst.ovr", overrun, 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int hyst_s[7]   = '{1500, 2000, 1200, 999, -2000, -1001, -999};
  int hyst_exp[7] = '{0, 1, 1, 0, 2, 2, 0};

  initial begin
    reset_n = 1'b0; sample_tick = 1'b0; fir_value = '0; out_ready = 1'b0;
    overrun_clr = 1'b0; stat_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // basic scaling and latency
    run_sample("basic", 819200, 1'b1, 1'b1);
    check("basic.const", $signed(out_data), 100);

    // rounding boundaries
    run_sample("rnd4096", 4096, 1'b1, 1'b1);
    check("rnd4096.const", $signed(out_data), 1);
    run_sample("rnd4095", 4095, 1'b1, 1'b1);
    run_sample("rndm4096", -4096, 1'b1, 1'b1);
    run_sample("rndm4097", -4097, 1'b1, 1'b1);
    check("rndm4097.const", $signed(out_data), -1);

    // hysteresis sequence
    for (int i = 0; i < 7; i++) begin
      run_sample("hyst", hyst_s[i] * 8192, 1'b1, 1'b1);
      check("hyst.const", tilt_dir, hyst_exp[i]);
    end

    // saturation, POS then directly NEG
    run_sample("satp", 32'h7FFF_FFFF, 1'b1, 1'b1);
    check("satp.const", $signed(out_data), 32767);
    run_sample("satn", int'(32'h8000_0000), 1'b1, 1'b1);
    check("satn.const", $signed(out_data), -32768);

    // overrun set, clear, and handshake-with-emit
    run_sample("ovr1", 10 * 8192, 1'b1, 1'b0);
    run_sample("ovr2", 20 * 8192, 1'b0, 1'b0);
    check("ovr2.const", overrun, 1);
    pulse_clr(1'b1, 1'b1);
    run_sample("hs_emit", 30 * 8192, 1'b0, 1'b1);
    check("hs_emit.const", overrun, 0);

    // decimation: 8 more ticks
    for (int i = 1; i <= 8; i++) run_sample("decim", i * 8192 * 100, 1'b1, 1'b1);

    // edge during SETTLE restarts capture with the later value
    out_ready = 1'b1; fir_value = 111 * 8192; sample_tick = 1'b1;
    @(negedge clk); model_consume(1'b1); sample_tick = 1'b0;
    @(negedge clk); fir_value = 222 * 8192; sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk); check("restart.pre1", out_valid, m_valid[0]);
    @(negedge clk); check("restart.pre2", out_valid, m_valid[0]);
    @(negedge clk); model_capture(222 * 8192, 1'b1); check_all("restart");

    // reset during SETTLE drops the pending sample
    fir_value = 500 * 8192; sample_tick = 1'b1;
    @(negedge clk); sample_tick = 1'b0;
    @(negedge clk);
    do_reset();
    repeat (4) @(negedge clk);
    check_all("rst_mid");

    // randomised traffic
    for (int n = 0; n < 80; n++) begin
      int v;
      case ($urandom_range(0, 3))
        0: v = int'($urandom);
        1: v = ($urandom_range(0, 6000) - 3000) * 8192 + $urandom_range(0, 8191);
        2: v = int'($urandom_range(0, 1) != 0 ? 32'h7FF0_0000 + $urandom_range(0, 65535)
                                              : 32'h8000_0000 + $urandom_range(0, 65535));
        default: v = ($urandom_range(0, 80000) - 40000) * 8192 + $urandom_range(0, 8191);
      endcase
      run_sample("rand", v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 7) == 0)
        pulse_clr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
